// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, header pack/unpack helpers and the
// NI transmit FSM state encoding.
package noc_pkg;

  localparam int COORD_W = 2;
  localparam int LEN_W   = 4;
  localparam int FLIT_W  = 2*COORD_W + LEN_W;

  typedef struct packed {
    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;
    logic [LEN_W-1:0]   len;
  } hdr_t;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} ni_state_e;

  function automatic logic [FLIT_W-1:0] pack_header(hdr_t h);
    return {h.dst_x, h.dst_y, h.len};
  endfunction

  function automatic hdr_t unpack_header(logic [FLIT_W-1:0] f);
    hdr_t h;
    h.dst_x = f[FLIT_W-1 -: COORD_W];
    h.dst_y = f[LEN_W +: COORD_W];
    h.len   = f[LEN_W-1:0];
    return h;
  endfunction

endpackage

// File: rtl/ni_credit_counter.sv
// Downstream-FIFO credit tracker shared by all NI ports. Starts full; a
// returned credit with the counter already full is flagged as a sticky error.
module ni_credit_counter #(
  parameter int CREDITS = 8,
  parameter int CW      = $clog2(CREDITS+1)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          consume,
  input  logic          credit_in,
  output logic [CW-1:0] cnt,
  output logic          has_credit,
  output logic          credit_err
);

  localparam logic [CW-1:0] MAX = CW'(CREDITS);

  assign has_credit = (cnt != '0);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt        <= MAX;
      credit_err <= 1'b0;
    end else begin
      // Simultaneous consume and return cancel out; consume is gated upstream by has_credit.
      if (consume && !credit_in) begin
        cnt <= cnt - CW'(1);
      end else if (credit_in && !consume) begin
        if (cnt == MAX) credit_err <= 1'b1;
        else            cnt        <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ni_packetizer.sv
// NI transmit side for the router local port: header flit + LEN body flits,
// credit-gated so the router's local input FIFO can never overflow.
module ni_packetizer
  import noc_pkg::*;
#(
  parameter int CREDITS = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_dst_x,
  input  logic [COORD_W-1:0] req_dst_y,
  input  logic [LEN_W-1:0]   req_len,
  input  logic               pl_valid,
  output logic               pl_ready,
  input  logic [FLIT_W-1:0]  pl_data,
  output logic [FLIT_W-1:0]  flit_out,
  output logic               Write,
  input  logic               credit_in,
  output logic               pkt_done,
  output logic               busy,
  output logic               credit_err
);

  localparam int CW = $clog2(CREDITS+1);

  ni_state_e         state, state_nxt;
  hdr_t              hdr_q;
  logic [LEN_W-1:0]  remaining;
  logic              send, done_nxt, has_credit;
  logic [FLIT_W-1:0] flit_nxt;
  logic [CW-1:0]     cnt;

  ni_credit_counter #(.CREDITS(CREDITS), .CW(CW)) u_credit (
    .Clk        (Clk),
    .Rst        (Rst),
    .consume    (send),
    .credit_in  (credit_in),
    .cnt        (cnt),
    .has_credit (has_credit),
    .credit_err (credit_err)
  );

  assign req_ready = (state == IDLE);
  assign pl_ready  = (state == BODY) && has_credit;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    send      = 1'b0;
    done_nxt  = 1'b0;
    flit_nxt  = pl_data;
    case (state)
      IDLE: if (req_valid) state_nxt = HEAD;
      HEAD: if (has_credit) begin
        send     = 1'b1;
        flit_nxt = pack_header(hdr_q);
        if (hdr_q.len == '0) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = BODY;
        end
      end
      BODY: if (pl_valid && has_credit) begin
        send = 1'b1;
        if (remaining == LEN_W'(1)) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      hdr_q     <= '0;
      remaining <= '0;
      flit_out  <= '0;
      Write     <= 1'b0;
      pkt_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      Write    <= send;
      pkt_done <= done_nxt;
      if (send) flit_out <= flit_nxt;
      if (state == IDLE && req_valid) begin
        hdr_q.dst_x <= req_dst_x;
        hdr_q.dst_y <= req_dst_y;
        hdr_q.len   <= req_len;
      end
      if (state == HEAD && send)      remaining <= hdr_q.len;
      else if (state == BODY && send) remaining <= remaining - LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_ni_packetizer.sv
// Directed bench for ni_packetizer: header/body sequencing, credit stall and
// release, credit overflow flag and mid-packet reset.
module tb_ni_packetizer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       req_valid, req_ready;
  logic [1:0] req_dst_x, req_dst_y;
  logic [3:0] req_len;
  logic       pl_valid, pl_ready;
  logic [7:0] pl_data, flit_out;
  logic       Write, credit_in, pkt_done, busy, credit_err;

  int total = 0;
  int bad   = 0;

  ni_packetizer #(.CREDITS(8)) dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_len(req_len),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .flit_out(flit_out), .Write(Write), .credit_in(credit_in),
    .pkt_done(pkt_done), .busy(busy), .credit_err(credit_err)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  task automatic request(input logic [1:0] x, input logic [1:0] y, input logic [3:0] len);
    req_valid = 1'b1; req_dst_x = x; req_dst_y = y; req_len = len;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; req_valid = 1'b0; req_dst_x = '0; req_dst_y = '0; req_len = '0;
    pl_valid = 1'b0; pl_data = '0; credit_in = 1'b0;
    do_reset();

    // reset state
    chk("rst_write", 32'(Write), 0);
    chk("rst_flit", 32'(flit_out), 0);
    chk("rst_done", 32'(pkt_done), 0);
    chk("rst_err", 32'(credit_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_cnt", 32'(dut.u_credit.cnt), 8);

    // 1: dst=(2,1), len=3 -> 0x93, A1, A2, A3
    request(2'd2, 2'd1, 4'd3);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_req_ready", 32'(req_ready), 0);
    chk("t1_head_pl_ready", 32'(pl_ready), 0);
    pl_valid = 1'b1; pl_data = 8'hA1;
    tick();
    chk("t1_hdr_write", 32'(Write), 1);
    chk("t1_hdr_flit", 32'(flit_out), 'h93);
    chk("t1_hdr_done", 32'(pkt_done), 0);
    tick();
    chk("t1_b1", 32'(flit_out), 'hA1);
    chk("t1_b1_write", 32'(Write), 1);
    pl_data = 8'hA2;
    tick();
    chk("t1_b2", 32'(flit_out), 'hA2);
    pl_data = 8'hA3;
    tick();
    chk("t1_b3", 32'(flit_out), 'hA3);
    chk("t1_b3_write", 32'(Write), 1);
    chk("t1_done", 32'(pkt_done), 1);
    chk("t1_cnt", 32'(dut.u_credit.cnt), 4);
    pl_valid = 1'b0;
    tick();
    chk("t1_after_write", 32'(Write), 0);
    chk("t1_after_done", 32'(pkt_done), 0);
    chk("t1_after_busy", 32'(busy), 0);

    // 2: header-only packet dst=(3,3)
    request(2'd3, 2'd3, 4'd0);
    tick();
    chk("t2_write", 32'(Write), 1);
    chk("t2_flit", 32'(flit_out), 'hF0);
    chk("t2_done", 32'(pkt_done), 1);
    chk("t2_idle", 32'(req_ready), 1);
    tick();
    chk("t2_write_once", 32'(Write), 0);
    chk("t2_cnt", 32'(dut.u_credit.cnt), 3);

    // 3: len=10 with 8 credits -> stall after 8 flits
    do_reset();
    request(2'd0, 2'd0, 4'd10);
    pl_valid = 1'b1; pl_data = 8'h10;
    tick();
    chk("t3_hdr", 32'(flit_out), 'h0A);
    for (int i = 0; i < 7; i++) begin
      chk("t3_pl_ready", 32'(pl_ready), 1);
      tick();
      chk("t3_body_write", 32'(Write), 1);
      chk("t3_body_flit", 32'(flit_out), 32'('h10 + i));
      pl_data = pl_data + 8'd1;
    end
    chk("t3_cnt_zero", 32'(dut.u_credit.cnt), 0);
    chk("t3_stall_pl_ready", 32'(pl_ready), 0);
    tick();
    chk("t3_stall_write", 32'(Write), 0);
    tick();
    chk("t3_stall_write2", 32'(Write), 0);
    chk("t3_stall_busy", 32'(busy), 1);

    // 3/4: each returned credit (with pl_valid held) releases one flit
    for (int k = 0; k < 3; k++) begin
      credit_in = 1'b1;
      tick();
      credit_in = 1'b0;
      chk("t4_cnt_one", 32'(dut.u_credit.cnt), 1);
      chk("t4_pl_ready", 32'(pl_ready), 1);
      chk("t4_no_write_yet", 32'(Write), 0);
      tick();
      chk("t3_rel_write", 32'(Write), 1);
      chk("t3_rel_flit", 32'(flit_out), 32'('h17 + k));
      chk("t3_rel_done", 32'(pkt_done), (k == 2) ? 1 : 0);
      chk("t4_cnt_back", 32'(dut.u_credit.cnt), 0);
      pl_data = pl_data + 8'd1;
    end
    pl_valid = 1'b0;
    tick();
    chk("t3_end_busy", 32'(busy), 0);
    chk("t3_end_write", 32'(Write), 0);

    // 5: credit return with counter full
    do_reset();
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk("t5_cnt", 32'(dut.u_credit.cnt), 8);
    chk("t5_err", 32'(credit_err), 1);
    tick();
    tick();
    chk("t5_err_sticky", 32'(credit_err), 1);
    do_reset();
    chk("t5_err_cleared", 32'(credit_err), 0);

    // 6: reset mid-body after 2 of 5 body flits
    request(2'd1, 2'd2, 4'd5);
    pl_valid = 1'b1; pl_data = 8'h21;
    tick();
    chk("t6_hdr", 32'(flit_out), 'h65);
    tick();
    chk("t6_b1", 32'(flit_out), 'h21);
    pl_data = 8'h22;
    tick();
    chk("t6_b2", 32'(flit_out), 'h22);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    pl_valid = 1'b0;
    chk("t6_rst_write", 32'(Write), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_cnt", 32'(dut.u_credit.cnt), 8);
    chk("t6_rst_req_ready", 32'(req_ready), 1);
    request(2'd2, 2'd2, 4'd2);
    pl_valid = 1'b1; pl_data = 8'hB1;
    tick();
    chk("t6_new_hdr", 32'(flit_out), 'hA2);
    tick();
    chk("t6_new_b1", 32'(flit_out), 'hB1);
    chk("t6_new_b1_done", 32'(pkt_done), 0);
    pl_data = 8'hB2;
    tick();
    chk("t6_new_b2", 32'(flit_out), 'hB2);
    chk("t6_new_done", 32'(pkt_done), 1);
    chk("t6_new_cnt", 32'(dut.u_credit.cnt), 5);
    pl_valid = 1'b0;
    tick();
    chk("t6_new_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
